// File: rtl/dpu_requant_pkg.sv
// Shared widths, INT8 result type and the saturation helper for the requantize/pack path.
package dpu_requant_pkg;

  localparam int ACC_W     = 32;
  localparam int PROD_W    = 48;
  localparam int SUM_W     = PROD_W + 2;
  localparam int Q_MIN     = -128;
  localparam int Q_MAX     = 127;
  localparam int MAX_SHIFT = 47;
  localparam int SHIFT_CW  = $clog2(MAX_SHIFT + 1);

  typedef logic signed [7:0] int8_t;

  localparam logic signed [SUM_W-1:0] T_MAX = SUM_W'(Q_MAX);
  localparam logic signed [SUM_W-1:0] T_MIN = SUM_W'(Q_MIN);

  function automatic int8_t saturate(input logic signed [SUM_W-1:0] t);
    int8_t r;
    if (t > T_MAX)      r = int8_t'(Q_MAX);
    else if (t < T_MIN) r = int8_t'(Q_MIN);
    else                r = t[7:0];
    return r;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Two-stage requantizer: stage 1 multiplies and clamps the shift, stage 2 rounds,
// shifts, adds the zero point and saturates. Valid and flush markers travel alongside.
module requant_lane
  import dpu_requant_pkg::*;
#(
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic               flush,
  input  logic [ACC_W-1:0]   x,
  input  logic [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [7:0]         zero_point,
  output logic               q_valid,
  output logic               q_flush,
  output int8_t              q,
  output logic               stage_busy
);

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] scale_ext;
  logic signed [PROD_W-1:0] prod;
  logic [SHIFT_CW-1:0]      shift_c;

  logic                     s1_valid;
  logic                     s1_flush;
  logic signed [PROD_W-1:0] s1_prod;
  logic [SHIFT_CW-1:0]      s1_shift;
  logic [7:0]               s1_zp;

  logic signed [PROD_W:0]   ext;
  logic signed [PROD_W:0]   rnd;
  logic signed [PROD_W:0]   sum;
  logic signed [PROD_W:0]   shifted;
  logic signed [SUM_W-1:0]  t;

  // Operands widened to the full product width so the multiply is not truncated.
  assign x_ext     = $signed({{(PROD_W-ACC_W){x[ACC_W-1]}}, x});
  assign scale_ext = $signed({{(PROD_W-SCALE_W){1'b0}}, scale});
  assign prod      = x_ext * scale_ext;
  assign shift_c   = (32'(shift) > MAX_SHIFT) ? SHIFT_CW'(MAX_SHIFT) : SHIFT_CW'(shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
    end else begin
      s1_valid <= valid;
      s1_flush <= flush;
      if (valid) begin
        s1_prod  <= prod;
        s1_shift <= shift_c;
        s1_zp    <= zero_point;
      end
    end
  end

  // One extra bit of headroom: the rounding constant can push a near-max product past 2^47.
  always_comb begin
    ext = $signed({s1_prod[PROD_W-1], s1_prod});
    rnd = '0;
    if (s1_shift != '0) rnd[s1_shift - SHIFT_CW'(1)] = 1'b1;
    sum     = ext + rnd;
    shifted = sum >>> s1_shift;
    t       = $signed({shifted[PROD_W], shifted}) +
              $signed({{(SUM_W-8){s1_zp[7]}}, s1_zp});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_flush <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= s1_valid;
      q_flush <= s1_flush;
      if (s1_valid) q <= saturate(t);
    end
  end

  assign stage_busy = s1_valid | s1_flush | q_valid | q_flush;

endmodule

// File: rtl/requant_pack.sv
// Requantize INT32 activations to INT8 and pack LANES results per 32-bit output word,
// with explicit flush for partial words.
module requant_pack
  import dpu_requant_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [ACC_W-1:0]   x,
  input  logic [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [7:0]         zero_point,
  input  logic               flush,
  output logic [LANES*8-1:0] word_out,
  output logic [LANES-1:0]   byte_mask,
  output logic               word_valid,
  output logic               busy
);

  localparam int CNT_W = $clog2(LANES + 1);

  logic               q_valid;
  logic               q_flush;
  int8_t              q;
  logic               stage_busy;

  logic [CNT_W-1:0]   lane_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [LANES*8-1:0] acc;
  logic [LANES*8-1:0] acc_next;
  logic [LANES-1:0]   mask_next;
  logic               emit;

  requant_lane #(
    .SCALE_W (SCALE_W),
    .SHIFT_W (SHIFT_W)
  ) u_lane (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .flush      (flush),
    .x          (x),
    .scale      (scale),
    .shift      (shift),
    .zero_point (zero_point),
    .q_valid    (q_valid),
    .q_flush    (q_flush),
    .q          (q),
    .stage_busy (stage_busy)
  );

  always_comb begin
    acc_next = acc;
    cnt_next = lane_cnt;
    if (q_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_cnt == CNT_W'(i)) acc_next[8*i +: 8] = q;
      end
      cnt_next = lane_cnt + CNT_W'(1);
    end
    for (int i = 0; i < LANES; i++) begin
      mask_next[i] = CNT_W'(i) < cnt_next;
    end
    // A flush reaching an empty packer emits nothing; a full word with flush emits once.
    emit = (q_valid && (cnt_next == CNT_W'(LANES))) || (q_flush && (cnt_next != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out   <= '0;
      byte_mask  <= '0;
      word_valid <= 1'b0;
      acc        <= '0;
      lane_cnt   <= '0;
    end else begin
      word_valid <= emit;
      if (emit) begin
        word_out  <= acc_next;
        byte_mask <= mask_next;
        acc       <= '0;
        lane_cnt  <= '0;
      end else begin
        acc      <= acc_next;
        lane_cnt <= cnt_next;
      end
    end
  end

  assign busy = stage_busy | (lane_cnt != '0);

endmodule
